// File: rtl/ghost_mode_if.sv
// Handshake bundle between the ghost mode scheduler and its environment:
// timing/event pulses in, shared ghost mode and pen release mask out.
interface ghost_mode_if;
  logic       sec;
  logic       restart;
  logic       lifeDown;
  logic       power_pellet;
  logic [1:0] mode;
  logic       reverse;
  logic       flash;
  logic [3:0] release_vec;
  logic [2:0] phase;

  modport master (
    output sec, restart, lifeDown, power_pellet,
    input  mode, reverse, flash, release_vec, phase
  );

  modport slave (
    input  sec, restart, lifeDown, power_pellet,
    output mode, reverse, flash, release_vec, phase
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Global ghost behaviour sequencer: scatter/chase schedule, frightened mode
// after a power pellet, and staggered pen release, all timed by the sec tick.
module ghost_mode_scheduler #(
  parameter int SCATTER_SEC = 7,
  parameter int CHASE_SEC   = 20,
  parameter int NUM_PHASES  = 4,
  parameter int FRIGHT_SEC  = 6,
  parameter int FLASH_SEC   = 2,
  parameter int RELEASE_SEC = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  ghost_mode_if.slave  bus
);

  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    CHASE   = 2'd1,
    FRIGHT  = 2'd2
  } mode_e;

  localparam logic [5:0] SCATTER_LAST = 6'(SCATTER_SEC - 1);
  localparam logic [5:0] CHASE_LAST   = 6'(CHASE_SEC - 1);
  localparam logic [5:0] FRIGHT_LAST  = 6'(FRIGHT_SEC - 1);
  localparam logic [5:0] RELEASE_LAST = 6'(RELEASE_SEC - 1);
  localparam logic [5:0] FLASH_THR    = 6'(FRIGHT_SEC - FLASH_SEC);
  localparam logic [2:0] PHASE_LAST   = 3'(NUM_PHASES - 1);
  localparam logic       FLASH_EN     = (FLASH_SEC != 0);

  mode_e      mode_q, mode_n;
  mode_e      saved_q, saved_n;
  logic [2:0] phase_q, phase_n;
  logic [5:0] sched_cnt_q, sched_cnt_n;
  logic [5:0] fright_cnt_q, fright_cnt_n;
  logic [5:0] rel_cnt_q, rel_cnt_n;
  logic [3:0] release_q, release_n;
  logic       reverse_q, reverse_n;
  logic       flash_q, flash_n;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q       <= SCATTER;
      saved_q      <= SCATTER;
      phase_q      <= 3'd0;
      sched_cnt_q  <= 6'd0;
      fright_cnt_q <= 6'd0;
      rel_cnt_q    <= 6'd0;
      release_q    <= 4'b0001;
      reverse_q    <= 1'b0;
      flash_q      <= 1'b0;
    end else begin
      mode_q       <= mode_n;
      saved_q      <= saved_n;
      phase_q      <= phase_n;
      sched_cnt_q  <= sched_cnt_n;
      fright_cnt_q <= fright_cnt_n;
      rel_cnt_q    <= rel_cnt_n;
      release_q    <= release_n;
      reverse_q    <= reverse_n;
      flash_q      <= flash_n;
    end
  end

  always_comb begin
    mode_n       = mode_q;
    saved_n      = saved_q;
    phase_n      = phase_q;
    sched_cnt_n  = sched_cnt_q;
    fright_cnt_n = fright_cnt_q;
    rel_cnt_n    = rel_cnt_q;
    release_n    = release_q;
    reverse_n    = 1'b0;

    if (bus.restart || bus.lifeDown) begin
      mode_n       = SCATTER;
      saved_n      = SCATTER;
      phase_n      = 3'd0;
      sched_cnt_n  = 6'd0;
      fright_cnt_n = 6'd0;
      rel_cnt_n    = 6'd0;
      release_n    = 4'b0001;
    end else begin
      // Pen release runs regardless of mode or a coincident pellet.
      if (bus.sec && release_q != 4'b1111) begin
        if (rel_cnt_q == RELEASE_LAST) begin
          release_n = {release_q[2:0], 1'b1};
          rel_cnt_n = 6'd0;
        end else begin
          rel_cnt_n = rel_cnt_q + 6'd1;
        end
      end

      if (bus.power_pellet) begin
        if (mode_q != FRIGHT) begin
          saved_n   = mode_q;
          reverse_n = 1'b1;
        end
        mode_n       = FRIGHT;
        fright_cnt_n = 6'd0;
      end else if (bus.sec) begin
        unique case (mode_q)
          SCATTER: begin
            if (sched_cnt_q == SCATTER_LAST) begin
              mode_n      = CHASE;
              sched_cnt_n = 6'd0;
              reverse_n   = 1'b1;
            end else begin
              sched_cnt_n = sched_cnt_q + 6'd1;
            end
          end
          CHASE: begin
            // Final phase: chase is permanent and the counter holds.
            if (phase_q < PHASE_LAST) begin
              if (sched_cnt_q == CHASE_LAST) begin
                mode_n      = SCATTER;
                phase_n     = phase_q + 3'd1;
                sched_cnt_n = 6'd0;
                reverse_n   = 1'b1;
              end else begin
                sched_cnt_n = sched_cnt_q + 6'd1;
              end
            end
          end
          FRIGHT: begin
            if (fright_cnt_q == FRIGHT_LAST) begin
              mode_n       = saved_q;
              fright_cnt_n = 6'd0;
            end else begin
              fright_cnt_n = fright_cnt_q + 6'd1;
            end
          end
          default: mode_n = SCATTER;
        endcase
      end
    end

    flash_n = FLASH_EN && (mode_n == FRIGHT) && (fright_cnt_n >= FLASH_THR);
  end

  assign bus.mode        = mode_q;
  assign bus.reverse     = reverse_q;
  assign bus.flash       = flash_q;
  assign bus.release_vec = release_q;
  assign bus.phase       = phase_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Scoreboard bench for ghost_mode_scheduler: a countdown-based reference
// model predicts every cycle's outputs; a monitor compares them.
module tb_ghost_mode_scheduler;

  localparam int SCATTER_SEC = 2;
  localparam int CHASE_SEC   = 3;
  localparam int NUM_PHASES  = 2;
  localparam int FRIGHT_SEC  = 3;
  localparam int FLASH_SEC   = 1;
  localparam int RELEASE_SEC = 2;

  localparam int M_SCATTER = 0;
  localparam int M_CHASE   = 1;
  localparam int M_FRIGHT  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ghost_mode_if bus ();

  ghost_mode_scheduler #(
    .SCATTER_SEC (SCATTER_SEC),
    .CHASE_SEC   (CHASE_SEC),
    .NUM_PHASES  (NUM_PHASES),
    .FRIGHT_SEC  (FRIGHT_SEC),
    .FLASH_SEC   (FLASH_SEC),
    .RELEASE_SEC (RELEASE_SEC)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    int mode;
    int rev;
    int flash;
    int rel;
    int phase;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: remaining-seconds countdowns and a released-ghost count.
  int m_mode, m_saved, m_phase, m_sched_left, m_fright_left, m_rel_left, m_nrel;
  int m_rev;

  function automatic void model_reset();
    m_mode        = M_SCATTER;
    m_saved       = M_SCATTER;
    m_phase       = 0;
    m_sched_left  = SCATTER_SEC;
    m_fright_left = FRIGHT_SEC;
    m_rel_left    = RELEASE_SEC;
    m_nrel        = 1;
    m_rev         = 0;
  endfunction

  function automatic void model_step(input bit s, input bit pp, input bit life,
                                     input bit rs_any);
    m_rev = 0;
    if (rs_any || life) begin
      model_reset();
      return;
    end
    if (s && m_nrel < 4) begin
      m_rel_left--;
      if (m_rel_left == 0) begin
        m_nrel++;
        m_rel_left = RELEASE_SEC;
      end
    end
    if (pp) begin
      if (m_mode != M_FRIGHT) begin
        m_saved = m_mode;
        m_rev   = 1;
      end
      m_mode        = M_FRIGHT;
      m_fright_left = FRIGHT_SEC;
    end else if (s) begin
      if (m_mode == M_FRIGHT) begin
        m_fright_left--;
        if (m_fright_left == 0) m_mode = m_saved;
      end else if (m_mode == M_SCATTER) begin
        m_sched_left--;
        if (m_sched_left == 0) begin
          m_mode       = M_CHASE;
          m_sched_left = CHASE_SEC;
          m_rev        = 1;
        end
      end else if (m_phase < NUM_PHASES - 1) begin
        m_sched_left--;
        if (m_sched_left == 0) begin
          m_mode       = M_SCATTER;
          m_phase++;
          m_sched_left = SCATTER_SEC;
          m_rev        = 1;
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.mode  = m_mode;
    e.rev   = m_rev;
    e.flash = (m_mode == M_FRIGHT && FLASH_SEC > 0 && m_fright_left <= FLASH_SEC) ? 1 : 0;
    e.rel   = (1 << m_nrel) - 1;
    e.phase = m_phase;
    return e;
  endfunction

  task automatic drive(input bit s, input bit pp, input bit life, input bit rstart,
                       input bit rs);
    @(negedge clk);
    bus.sec          = s;
    bus.power_pellet = pp;
    bus.lifeDown     = life;
    bus.restart      = rstart;
    rst              = rs;
    model_step(s, pp, life, rstart || rs);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) begin
      idle(9);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pellet();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pellet_with_sec();
    idle(9);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic life_down();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic restart_pulse();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: every cycle the DUT presents a registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mode",    int'(bus.mode),        e.mode);
        chk("reverse", int'(bus.reverse),     e.rev);
        chk("flash",   int'(bus.flash),       e.flash);
        chk("release", int'(bus.release_vec), e.rel);
        chk("phase",   int'(bus.phase),       e.phase);
      end
    end
  end

  initial begin
    bus.sec          = 1'b0;
    bus.power_pellet = 1'b0;
    bus.lifeDown     = 1'b0;
    bus.restart      = 1'b0;
    rst              = 1'b1;
    model_reset();

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Full schedule into permanent chase
    secs(2); secs(3); secs(2); secs(10);

    // Fright pauses the schedule and resumes it
    restart_pulse();
    secs(1); pellet(); secs(3); secs(1); secs(1);

    // Pellet during fright restarts the fright timer
    restart_pulse();
    pellet(); secs(2); pellet(); secs(3); secs(1);

    // Release sequence, sticky through a fright interval
    restart_pulse();
    secs(6); pellet(); secs(3); secs(2);

    // lifeDown in fright with three ghosts released
    restart_pulse();
    secs(4); pellet(); secs(1); life_down(); idle(2); secs(2);

    // Pellet coinciding with the scatter-expiry tick
    restart_pulse();
    secs(1); pellet_with_sec(); secs(3); secs(1);

    // Restart mid-chase
    restart_pulse();
    secs(3); restart_pulse(); idle(3);

    // Randomized traffic with single-cycle sec every tenth cycle
    for (int c = 0; c < 3000; c++) begin
      bit s, pp, lf, rsp;
      s   = (c % 10 == 9);
      pp  = ($urandom_range(0, 39) == 0);
      lf  = ($urandom_range(0, 249) == 0);
      rsp = ($urandom_range(0, 399) == 0);
      drive(s, pp, lf, rsp, 1'b0);
    end

    // Reset mid-stream returns to reset values
    secs(2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ghost_mode_scheduler.md
Name: ghost_mode_scheduler

Overview:
- Global behaviour sequencer for the four ghosts. Steps the shared ghost mode through the scatter/chase schedule, drives frightened mode after a power pellet, and staggers ghost release from the pen.
- Timed entirely by the one-cycle `sec` tick from second_counter.
- Outputs fan out to redghost and the other ghost movers, which pick their target and direction logic from `mode`.

Parameters:
- SCATTER_SEC, 7, seconds per scatter phase (1..63)
- CHASE_SEC, 20, seconds per non-final chase phase (1..63)
- NUM_PHASES, 4, scatter phases before chase becomes permanent (1..7)
- FRIGHT_SEC, 6, frightened duration in seconds (1..63)
- FLASH_SEC, 2, trailing frightened seconds with flash asserted (0..FRIGHT_SEC)
- RELEASE_SEC, 4, seconds between successive ghost releases (1..63)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- sec  in  1  one-Clk-cycle pulse once per second
- restart  in  1  new game/level pulse; same effect as Reset
- lifeDown  in  1  pulse when Pac-Man loses a life
- power_pellet  in  1  pulse when Pac-Man eats a power pellet
- mode  out  2  0 = SCATTER, 1 = CHASE, 2 = FRIGHT (3 is never driven)
- reverse  out  1  one-cycle pulse: all ghosts reverse direction
- flash  out  1  frightened ghosts blink (end-of-fright warning)
- release  out  4  bit i = ghost i may leave the pen (sticky)
- phase  out  3  current scatter/chase phase index, for debug

Behaviour:
- All outputs are registered.
- Reset or restart values:
  - mode = SCATTER, phase = 0, reverse = 0, flash = 0, release = 4'b0001.
  - Internal counters sched_cnt, fright_cnt and rel_cnt = 0.
  - saved_mode = SCATTER.
- Priority within a cycle: Reset > restart > lifeDown > power_pellet > sec-driven timing.
- Counters are 6 bits. A counter advances only on a cycle with sec = 1.
- SCATTER state:
  - On sec, if sched_cnt == SCATTER_SEC-1: mode <= CHASE, sched_cnt <= 0, reverse = 1 on the same edge.
  - Otherwise on sec: sched_cnt++.
- CHASE state:
  - If phase < NUM_PHASES-1 and sec and sched_cnt == CHASE_SEC-1: mode <= SCATTER, phase++, sched_cnt <= 0, reverse = 1.
  - If phase == NUM_PHASES-1: chase is permanent and sched_cnt holds.
- power_pellet while in SCATTER or CHASE:
  - saved_mode <= mode; sched_cnt and phase freeze.
  - mode <= FRIGHT, fright_cnt <= 0, reverse = 1, flash = 0.
- power_pellet while in FRIGHT:
  - fright_cnt <= 0, flash <= 0.
  - No reverse, and saved_mode is unchanged.
- FRIGHT state:
  - On sec: fright_cnt++.
  - flash = 1 whenever fright_cnt >= FRIGHT_SEC-FLASH_SEC. When FLASH_SEC = 0, flash never asserts.
  - On sec with fright_cnt == FRIGHT_SEC-1: mode <= saved_mode, flash <= 0, no reverse. The schedule resumes with the frozen sched_cnt and phase.
- When power_pellet coincides with sec, the schedule/fright tick for that cycle is dropped, and the pellet action is taken.
- Release logic:
  - Independent of mode, and keeps counting during FRIGHT.
  - While release != 4'b1111, on sec: rel_cnt++.
  - On sec with rel_cnt == RELEASE_SEC-1: release <= {release[2:0],1'b1}, rel_cnt <= 0.
  - At 4'b1111, rel_cnt holds at 0.
  - The rel_cnt tick is NOT dropped by a coincident power_pellet.
- lifeDown:
  - mode <= SCATTER, phase <= 0, all counters <= 0, release <= 4'b0001, flash <= 0, no reverse.
  - Any pending FRIGHT is discarded and saved_mode <= SCATTER.
  - A sec or power_pellet in the same cycle is ignored.
- reverse is high for exactly one Clk cycle per qualifying event and is never asserted by lifeDown, restart or Reset.
- sec held high for multiple cycles counts once per high cycle. The design relies on a single-cycle pulse; the bench must not violate this.

Test Plan:
- Bench overrides SCATTER_SEC=2, CHASE_SEC=3, NUM_PHASES=2, FRIGHT_SEC=3, FLASH_SEC=1, RELEASE_SEC=2, and drives sec every 10 cycles.
- Schedule: Reset, then 2 sec -> mode=CHASE, reverse 1 cycle; 3 more sec -> mode=SCATTER, phase=1, reverse; 2 more sec -> CHASE; then 10 more sec -> mode stays CHASE, no reverse.
- Fright pause: after 1 sec in SCATTER, pulse power_pellet -> mode=2, reverse 1 cycle, flash=0. After 2 sec flash=1; after the 3rd sec mode=SCATTER, flash=0. One further sec -> CHASE (sched_cnt resumed at 1).
- Pellet during fright: pellet, 2 sec, pellet again -> fright_cnt restarts, flash drops to 0, no reverse. FRIGHT lasts 3 more sec.
- Release: from Reset, release=0001; after 2 sec 0011, 4 sec 0111, 6 sec 1111; stays 1111 through a FRIGHT interval.
- lifeDown in FRIGHT with release=0111 -> next cycle mode=SCATTER, phase=0, release=0001, flash=0, reverse=0. Schedule restarts (2 sec -> CHASE).
- Simultaneous pellet+sec at scatter expiry -> mode=FRIGHT (not CHASE); after fright ends mode=SCATTER, then 1 sec -> CHASE.
- Restart mid-CHASE -> all outputs return to their reset values.
